// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
//   - default byte address of instruction word 0 (the core's reset PC)
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - word returned on an errored fetch
package imem_responder_pkg;

  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] ERR_FILL = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// DEPTH x ILEN synchronous instruction store.
//   clk       : clock
//   i_rd_en   : read enable; o_rd_data updates only when set
//   i_rd_idx  : word index to read
//   o_rd_data : registered read data, holds between reads
//   i_wr_en   : write strobe
//   i_wr_idx  : word index to write
//   i_wr_data : word to write
// A read and a write to the same word on one edge return the old word.
module imem_array #(
  parameter int ILEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [ILEN-1:0]          o_rd_data,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
  input  logic [ILEN-1:0]          i_wr_data
);

  logic [ILEN-1:0] r_mem [DEPTH];

  // NOTE: the store and its read register have no reset so they map onto
  // block RAM; preloaded contents survive a core reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read see the pre-write word,
    // which is exactly the read-before-write behaviour wanted here.
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_idx];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder on the core fetch path.
//   clk, rst              : clock, asynchronous active-low reset
//   req_valid/req_ready   : fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready   : response handshake
//   rsp_inst, rsp_err     : instruction word, misaligned/out-of-range flag
//   ld_en, ld_idx, ld_data: preload write port, usable in any state
// One request is outstanding at a time; the response appears LATENCY wait
// cycles after the accept and is held until the core takes it.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              ILEN    = 32,
  parameter int              DEPTH   = 1024,
  parameter logic [XLEN-1:0] BASE    = XLEN'(IMEM_BASE_DEFAULT),
  parameter int              LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ILEN-1:0]          rsp_inst,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [ILEN-1:0]          ld_data
);

  localparam int         IW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_addr;
  logic            r_err;

  logic [1:0]      w_next;
  logic            w_accept;
  logic            w_enter_resp;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_off;
  logic [IW-1:0]   w_idx;
  logic            w_bad;
  logic [ILEN-1:0] w_rd_data;

  // NOTE: every always_comb output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    w_accept     = (r_state == ST_IDLE) && req_valid;

    // With LATENCY=0 the array is read on the accept edge itself, before
    // r_addr holds the address, so the live request address is used then.
    w_addr = (r_state == ST_IDLE) ? req_addr : r_addr;
    w_off  = w_addr - BASE;
    w_idx  = w_off[IW+1:2];
    // The below-BASE test guards the subtraction, so a wrapped offset can
    // never look like a valid index. BASE is word aligned, so the low offset
    // bits equal the low address bits.
    w_bad  = (w_addr < BASE) || (|w_off[XLEN-1:IW+2]) || (|w_off[1:0]);

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (LAT == 4'd0) begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= req_addr;
        r_cnt  <= LAT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) r_err <= w_bad;
    end
  end

  imem_array #(
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk       (clk),
    .i_rd_en   (w_enter_resp && !w_bad),
    .i_rd_idx  (w_idx),
    .o_rd_data (w_rd_data),
    .i_wr_en   (ld_en),
    .i_wr_idx  (ld_idx),
    .i_wr_data (ld_data)
  );

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = rsp_valid && r_err;
  // Gating on RESP gives the zero value under reset and the error fill
  // without resetting the RAM read register.
  assign rsp_inst  = (rsp_valid && !r_err) ? w_rd_data : ILEN'(ERR_FILL);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance with LATENCY=2 and one
// with LATENCY=0, driven through shared tasks selected by 'sel'.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // a_* : LATENCY=2 instance, b_* : LATENCY=0 instance
  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_ld_en;
  logic [31:0] a_req_addr, a_rsp_inst, a_ld_data;
  logic [9:0]  a_ld_idx;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_ld_en;
  logic [31:0] b_req_addr, b_rsp_inst, b_ld_data;
  logic [9:0]  b_ld_idx;

  bit sel;
  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_inst;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign m_rsp_inst  = sel ? b_rsp_inst  : a_rsp_inst;

  imem_responder #(
    .XLEN(32), .ILEN(32), .DEPTH(1024), .BASE(BASE), .LATENCY(2)
  ) u_dut_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_inst(a_rsp_inst), .rsp_err(a_rsp_err),
    .ld_en(a_ld_en), .ld_idx(a_ld_idx), .ld_data(a_ld_data)
  );

  imem_responder #(
    .XLEN(32), .ILEN(32), .DEPTH(1024), .BASE(BASE), .LATENCY(0)
  ) u_dut_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_inst(b_rsp_inst), .rsp_err(b_rsp_err),
    .ld_en(b_ld_en), .ld_idx(b_ld_idx), .ld_data(b_ld_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [31:0] a);
    if (sel) begin b_req_valid = v; b_req_addr = a; end
    else     begin a_req_valid = v; a_req_addr = a; end
  endtask

  task automatic set_rsp_ready(input logic v);
    if (sel) b_rsp_ready = v; else a_rsp_ready = v;
  endtask

  task automatic set_ld(input logic en, input logic [9:0] idx, input logic [31:0] d);
    if (sel) begin b_ld_en = en; b_ld_idx = idx; b_ld_data = d; end
    else     begin a_ld_en = en; a_ld_idx = idx; a_ld_data = d; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    set_ld(1'b1, idx, d);
    tick();
    set_ld(1'b0, 10'd0, 32'd0);
  endtask

  // Waits (bounded) for rsp_valid; 'edges' counts on from its input value.
  task automatic wait_rsp(input string tag, inout int edges);
    while (!m_rsp_valid && edges < 20) begin
      tick();
      edges++;
    end
    check(tag, {31'd0, m_rsp_valid}, 32'd1);
  endtask

  // Full fetch with rsp_ready high; 'edges' counts the accept edge as 1.
  task automatic fetch(input string tag, input logic [31:0] addr,
                       output logic [31:0] inst, output logic err, output int edges);
    set_req(1'b1, addr);
    tick();
    set_req(1'b0, addr);
    edges = 1;
    wait_rsp({tag, "_valid"}, edges);
    inst = m_rsp_inst;
    err  = m_rsp_err;
    tick();
  endtask

  logic [31:0] inst;
  logic        err;
  int          edges;

  initial begin
    rst = 1'b0;
    sel = 1'b0;
    a_req_valid = 0; a_req_addr = 0; a_rsp_ready = 0; a_ld_en = 0; a_ld_idx = 0; a_ld_data = 0;
    b_req_valid = 0; b_req_addr = 0; b_rsp_ready = 0; b_ld_en = 0; b_ld_idx = 0; b_ld_data = 0;

    #1;
    check("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rst_rsp_inst",  m_rsp_inst, 32'd0);
    check("rst_rsp_err",   {31'd0, m_rsp_err}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rel_req_ready", {31'd0, m_req_ready}, 32'd1);

    // ---- LATENCY=2 instance ----
    set_rsp_ready(1'b1);
    preload(10'd0,    32'h0000_0413);
    preload(10'd1,    32'hCAFE_0001);
    preload(10'd2,    32'hCAFE_0002);
    preload(10'd4,    32'h0000_0444);
    preload(10'd1023, 32'h1234_5678);

    fetch("f0", BASE, inst, err, edges);
    check("f0_inst",  inst, 32'h0000_0413);
    check("f0_err",   {31'd0, err}, 32'd0);
    check("f0_edges", 32'(edges), 32'd3);

    fetch("mis", 32'h8000_0002, inst, err, edges);
    check("mis_err",  {31'd0, err}, 32'd1);
    check("mis_inst", inst, 32'd0);
    fetch("below", 32'h7FFF_FFFC, inst, err, edges);
    check("below_err",  {31'd0, err}, 32'd1);
    check("below_inst", inst, 32'd0);
    fetch("above", 32'h8000_1000, inst, err, edges);
    check("above_err", {31'd0, err}, 32'd1);
    fetch("top", 32'hFFFF_FFFC, inst, err, edges);
    check("top_err", {31'd0, err}, 32'd1);
    fetch("last", 32'h8000_0FFC, inst, err, edges);
    check("last_inst", inst, 32'h1234_5678);
    check("last_err",  {31'd0, err}, 32'd0);

    // Stall in RESP with a second request pending.
    set_rsp_ready(1'b0);
    set_req(1'b1, BASE + 32'd4);
    tick();
    set_req(1'b1, BASE + 32'd8);
    edges = 1;
    wait_rsp("stall_valid", edges);
    check("stall_inst0", m_rsp_inst, 32'hCAFE_0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid_hold", {31'd0, m_rsp_valid}, 32'd1);
      check("stall_inst_hold",  m_rsp_inst, 32'hCAFE_0001);
      check("stall_req_ready",  {31'd0, m_req_ready}, 32'd0);
    end
    set_rsp_ready(1'b1);
    tick();
    check("hs_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("hs_req_ready", {31'd0, m_req_ready}, 32'd1);
    tick();
    set_req(1'b0, 32'd0);
    check("pend_accepted", {31'd0, m_req_ready}, 32'd0);
    edges = 1;
    wait_rsp("pend_valid", edges);
    check("pend_inst", m_rsp_inst, 32'hCAFE_0002);
    tick();

    // Preload write to the word being read on the edge entering RESP.
    set_req(1'b1, BASE + 32'h10);
    tick();
    set_req(1'b0, 32'd0);
    tick();
    set_ld(1'b1, 10'd4, 32'hDEAD_BEEF);
    tick();
    set_ld(1'b0, 10'd0, 32'd0);
    check("rbw_valid", {31'd0, m_rsp_valid}, 32'd1);
    check("rbw_old",   m_rsp_inst, 32'h0000_0444);
    tick();
    fetch("rbw_re", BASE + 32'h10, inst, err, edges);
    check("rbw_new", inst, 32'hDEAD_BEEF);

    // Reset mid-WAIT.
    set_req(1'b1, BASE);
    tick();
    set_req(1'b0, 32'd0);
    check("wait_req_ready", {31'd0, m_req_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rstw_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rstw_req_ready", {31'd0, m_req_ready}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // Reset mid-RESP.
    set_rsp_ready(1'b0);
    set_req(1'b1, BASE);
    tick();
    set_req(1'b0, 32'd0);
    edges = 1;
    wait_rsp("rstr_pre_valid", edges);
    check("rstr_pre_inst", m_rsp_inst, 32'h0000_0413);
    #2 rst = 1'b0;
    #1;
    check("rstr_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rstr_rsp_inst",  m_rsp_inst, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    set_rsp_ready(1'b1);
    tick();
    fetch("post_rst", BASE, inst, err, edges);
    check("post_rst_inst", inst, 32'h0000_0413);

    // ---- LATENCY=0 instance: ten fetches in a row ----
    sel = 1'b1;
    set_rsp_ready(1'b1);
    for (int i = 0; i < 10; i++) preload(10'(i), 32'(i + 1));
    for (int i = 0; i < 10; i++) begin
      fetch("l0", BASE + 32'(4 * i), inst, err, edges);
      check("l0_inst",  inst, 32'(i + 1));
      check("l0_err",   {31'd0, err}, 32'd0);
      check("l0_edges", 32'(edges), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
